// File: rtl/cpu_step_ctrl.sv
// Execution controller: turns debounced step/run button levels into a one-cycle
// CPU clock enable, with single-step, divided free-run and PC-breakpoint halt.
module cpu_step_ctrl #(
    parameter int unsigned PC_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned RUN_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step_btn,
    input  logic                 run_btn,
    input  logic                 tick,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic [PC_WIDTH-1:0]  bp_addr,
    input  logic                 bp_en,
    output logic                 cpu_ce,
    output logic                 running,
    output logic                 halted_bp,
    output logic [CNT_WIDTH-1:0] step_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_BREAK
    } state_t;

    localparam logic [7:0]           DIV_LAST = 8'(RUN_DIV - 1);
    localparam logic [7:0]           DIV_ONE  = 8'd1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [7:0]           div_q, div_d;
    logic                 skip_bp_q, skip_bp_d;
    logic                 step_prev_q, run_prev_q;
    logic                 arm_q;
    logic                 cpu_ce_q, cpu_ce_d;
    logic                 running_q, running_d;
    logic                 halted_bp_q, halted_bp_d;
    logic [CNT_WIDTH-1:0] step_count_q, step_count_d;

    logic step_rise, run_rise, issue;

    // arm_q masks edges for the first clock after reset, so a button held
    // through reset release is absorbed into the prev registers silently.
    assign step_rise = arm_q & step_btn & ~step_prev_q;
    assign run_rise  = arm_q & run_btn  & ~run_prev_q;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        skip_bp_d = skip_bp_q;
        issue     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_rise) begin
                    state_d = S_RUN;
                    div_d   = '0;
                end else if (step_rise) begin
                    issue = 1'b1;
                end
            end
            S_RUN: begin
                if (run_rise) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (bp_en && (pc == bp_addr) && !skip_bp_q) begin
                            state_d = S_BREAK;
                        end else begin
                            issue     = 1'b1;
                            skip_bp_d = 1'b0;
                        end
                    end else begin
                        div_d = div_q + DIV_ONE;
                    end
                end
            end
            S_BREAK: begin
                if (run_rise) begin
                    state_d   = S_RUN;
                    skip_bp_d = 1'b1;
                end else if (step_rise) begin
                    issue   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cpu_ce_d     = issue;
        step_count_d = (issue && (step_count_q != '1)) ? step_count_q + CNT_ONE : step_count_q;
        running_d    = (state_d == S_RUN);
        halted_bp_d  = (state_d == S_BREAK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            skip_bp_q    <= 1'b0;
            step_prev_q  <= 1'b0;
            run_prev_q   <= 1'b0;
            arm_q        <= 1'b0;
            cpu_ce_q     <= 1'b0;
            running_q    <= 1'b0;
            halted_bp_q  <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            skip_bp_q    <= skip_bp_d;
            step_prev_q  <= step_btn;
            run_prev_q   <= run_btn;
            arm_q        <= 1'b1;
            cpu_ce_q     <= cpu_ce_d;
            running_q    <= running_d;
            halted_bp_q  <= halted_bp_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_ce     = cpu_ce_q;
    assign running    = running_q;
    assign halted_bp  = halted_bp_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed plus randomized bench for cpu_step_ctrl against a mode/tick-count
// reference model; narrow step counter so saturation is reachable quickly.
module tb_cpu_step_ctrl;

    localparam int PCW  = 16;
    localparam int CW   = 8;
    localparam int DIV  = 4;
    localparam int MAXC = (1 << CW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_BRK  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           step_btn, run_btn, tick, bp_en;
    logic [PCW-1:0] pc, bp_addr;
    logic           cpu_ce, running, halted_bp;
    logic [CW-1:0]  step_count;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int m_mode;
    int m_run_ticks;
    bit m_skip;
    bit m_prev_s, m_prev_r, m_armed;
    int m_issued;
    bit exp_ce;

    always #5 clk = ~clk;

    cpu_step_ctrl #(
        .PC_WIDTH (PCW),
        .CNT_WIDTH(CW),
        .RUN_DIV  (DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .step_btn  (step_btn),
        .run_btn   (run_btn),
        .tick      (tick),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_en     (bp_en),
        .cpu_ce    (cpu_ce),
        .running   (running),
        .halted_bp (halted_bp),
        .step_count(step_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode      = M_IDLE;
        m_run_ticks = 0;
        m_skip      = 0;
        m_prev_s    = 0;
        m_prev_r    = 0;
        m_armed     = 0;
        m_issued    = 0;
        exp_ce      = 0;
    endtask

    // One clock edge of the reference: issues happen every DIV-th tick counted since RUN entry.
    task automatic model_edge(input bit sb, input bit rb, input bit tk,
                              input bit be, input logic [PCW-1:0] p, input logic [PCW-1:0] ba);
        bit sr, rr;
        sr = m_armed && sb && !m_prev_s;
        rr = m_armed && rb && !m_prev_r;
        m_prev_s = sb;
        m_prev_r = rb;
        m_armed  = 1;
        exp_ce   = 0;
        if (m_mode == M_IDLE) begin
            if (rr) begin
                m_mode = M_RUN;
                m_run_ticks = 0;
            end else if (sr) exp_ce = 1;
        end else if (m_mode == M_RUN) begin
            if (rr) m_mode = M_IDLE;
            else if (tk) begin
                m_run_ticks++;
                if (m_run_ticks % DIV == 0) begin
                    if (be && p == ba && !m_skip) m_mode = M_BRK;
                    else begin
                        exp_ce = 1;
                        m_skip = 0;
                    end
                end
            end
        end else begin
            if (rr) begin
                m_mode = M_RUN;
                m_skip = 1;
            end else if (sr) begin
                exp_ce = 1;
                m_mode = M_IDLE;
            end
        end
        if (exp_ce && m_issued < MAXC) m_issued++;
    endtask

    task automatic check_all();
        check("cpu_ce", {31'd0, cpu_ce}, {31'd0, exp_ce});
        check("running", {31'd0, running}, (m_mode == M_RUN) ? 32'd1 : 32'd0);
        check("halted_bp", {31'd0, halted_bp}, (m_mode == M_BRK) ? 32'd1 : 32'd0);
        check("step_count", {24'd0, step_count}, m_issued);
    endtask

    // Advance one clock; the CPU model moves pc on each expected issue.
    task automatic cycle();
        bit sb, rb, tk, be;
        logic [PCW-1:0] p, ba;
        sb = step_btn; rb = run_btn; tk = tick; be = bp_en; p = pc; ba = bp_addr;
        @(posedge clk);
        model_edge(sb, rb, tk, be, p, ba);
        #1;
        check_all();
        if (exp_ce) pc = pc + 16'd1;
    endtask

    initial begin
        int n;
        int guard;

        // reset with step held high through release
        rst = 1'b0; step_btn = 1'b1; run_btn = 1'b0; tick = 1'b0;
        bp_en = 1'b0; pc = '0; bp_addr = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) cycle();

        // test 1: single step
        step_btn = 1'b0; cycle();
        step_btn = 1'b1; cycle();
        check("t1_pulse", {31'd0, cpu_ce}, 32'd1);
        repeat (4) cycle();

        // test 2: free-run, 12 ticks -> 3 pulses on every 4th tick
        step_btn = 1'b0;
        run_btn = 1'b1; cycle();
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick = 1'b1; cycle();
            check("t2_pos", {31'd0, cpu_ce}, (i % 4 == 3) ? 32'd1 : 32'd0);
            if (cpu_ce) n++;
            tick = 1'b0; cycle();
        end
        check("t2_count", n, 3);

        // test 3: breakpoint at 0x0010
        pc = 16'h000E; bp_addr = 16'h0010; bp_en = 1'b1; tick = 1'b1;
        guard = 0;
        while (!halted_bp && guard < 40) begin cycle(); guard++; end
        check("t3_halted", {31'd0, halted_bp}, 32'd1);
        check("t3_running", {31'd0, running}, 32'd0);
        check("t3_pc", pc, 32'h0010);
        bp_addr = 16'h0020;
        repeat (8) cycle();
        check("t3_bp_move", {31'd0, halted_bp}, 32'd1);
        bp_addr = 16'h0010;

        // test 4: resume passes the breakpoint once, then halts on return
        run_btn = 1'b0; cycle();
        run_btn = 1'b1;
        guard = 0;
        do begin cycle(); guard++; end while (!cpu_ce && guard < 20);
        check("t4_pass_pc", pc, 32'h0011);
        pc = 16'h0010;
        n = 0; guard = 0;
        while (!halted_bp && guard < 20) begin cycle(); if (cpu_ce) n++; guard++; end
        check("t4_rehalt", {31'd0, halted_bp}, 32'd1);
        check("t4_no_issue", n, 0);

        // test 5: step from BREAK to IDLE, then simultaneous step+run rise
        tick = 1'b0; run_btn = 1'b0; step_btn = 1'b0; cycle();
        step_btn = 1'b1; cycle();
        check("t5_brk_step", {31'd0, cpu_ce}, 32'd1);
        step_btn = 1'b0; cycle();
        step_btn = 1'b1; run_btn = 1'b1; cycle();
        check("t5_running", {31'd0, running}, 32'd1);
        check("t5_no_ce", {31'd0, cpu_ce}, 32'd0);

        // randomized phase
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 15) == 0) run_btn = ~run_btn;
            tick = 1'($urandom_range(0, 1));
            if (i % 32 == 0) bp_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) bp_addr = pc + 16'($urandom_range(0, 3));
            cycle();
            if (exp_ce && $urandom_range(0, 7) == 0) pc = bp_addr;
        end

        // test 6: saturation of the step counter
        bp_en = 1'b0; step_btn = 1'b0; tick = 1'b1;
        for (int k = 0; k < 4 && m_mode != M_RUN; k++) begin
            run_btn = 1'b0; cycle();
            run_btn = 1'b1; cycle();
        end
        repeat (1200) cycle();
        check("t6_sat", {24'd0, step_count}, MAXC);

        // reset while cpu_ce is high
        guard = 0;
        do begin cycle(); guard++; end while (!exp_ce && guard < 20);
        check("t6_ce_before_rst", {31'd0, cpu_ce}, 32'd1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
